ram_req_sequencer: RTL and testbench
====================================

Name: ram_req_sequencer

Overview:
- Request sequencer directly upstream of the team's 4x8 synchronous RAM.
- Accepts single read/write requests from a host over a valid/ready handshake and drives the RAM control pins (addr, RD, WE, CS, dataIn).
- For reads, captures the RAM's combinational dataOut and returns it on a response channel with backpressure.
- Exactly one RAM transaction is in flight at a time.

Parameters:
- ADDR_W, 2, RAM address width; 2^ADDR_W words.
- DATA_W, 8, data width.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  1  host request valid.
- req_ready  output  1  sequencer can accept a request.
- req_write  input  1  1 = write, 0 = read.
- req_addr  input  ADDR_W  target word.
- req_wdata  input  DATA_W  write data.
- rsp_valid  output  1  read data valid.
- rsp_ready  input  1  host accepts response.
- rsp_data  output  DATA_W  read data.
- ram_addr  output  ADDR_W  to RAM addr.
- ram_cs  output  1  to RAM CS.
- ram_we  output  1  to RAM WE.
- ram_rd  output  1  to RAM RD.
- ram_din  output  DATA_W  to RAM dataIn.
- ram_dout  input  DATA_W  from RAM dataOut; combinational, 0 when RD&CS is low.
- verify_err  output  1  sticky write-verify mismatch (see Optional Feature).

Behaviour:
- One clock, clk. Asynchronous active-high reset, reset.
- Reset state is IDLE. All registered outputs reset to 0: rsp_valid, rsp_data, ram_addr, ram_din, verify_err. ram_cs, ram_we and ram_rd are 0 immediately on reset assertion.
- FSM states: IDLE, WRITE, READ, RESP, VERIFY. VERIFY exists only with the feature enabled.
- req_ready = 1 only in IDLE. Handshake occurs when req_valid & req_ready at a rising edge. On handshake, latch req_addr into ram_addr and req_wdata into ram_din.
- IDLE -> WRITE on handshake with req_write=1.
- IDLE -> READ on handshake with req_write=0.
- WRITE (1 cycle):
  - ram_cs=1, ram_we=1, ram_rd=0; RAM commits the write on the closing edge.
  - Next state is IDLE, or VERIFY when the feature is enabled.
  - Writes produce no response.
- READ (1 cycle):
  - ram_cs=1, ram_rd=1, ram_we=0.
  - On the closing edge, rsp_data <= ram_dout; next state RESP.
- RESP:
  - rsp_valid=1; rsp_data held stable until rsp_ready=1.
  - On the edge with rsp_ready=1, go to IDLE; rsp_valid drops next cycle.
- Control pins are decoded from state only. ram_cs/ram_we/ram_rd are 0 in IDLE and RESP. ram_we and ram_rd are never both 1.
- Latency, write: handshake edge N; RAM written at edge N+1; req_ready=1 again in cycle after N+1. Sustained throughput 1 write per 2 cycles.
- Latency, read: handshake edge N; data captured at N+1; rsp_valid=1 in cycle after N+1. With rsp_ready tied high, throughput is 1 read per 3 cycles.
- Boundaries:
  - req_valid while busy is ignored; host must hold the request.
  - Address wrap is not applicable (full ADDR_W decode). Addresses 0 and 2^ADDR_W-1 must both be exercised.
  - rsp_ready low indefinitely stalls in RESP with no RAM activity.
  - Reset asserted mid-WRITE: CS/WE drop asynchronously, so the write may be lost. RAM content in that case is undefined and must not be relied on.
  - Reset asserted in RESP: the pending response is discarded.
  - Request inputs changing while not in IDLE have no effect.

Optional Feature:
- Macro: RAM_WRITE_VERIFY_EN.
- Defined:
  - WRITE is followed by a 1-cycle VERIFY state (ram_cs=1, ram_rd=1, same ram_addr).
  - At the closing edge of VERIFY, if ram_dout != ram_din, verify_err <= 1. verify_err is sticky until reset.
  - Next state is IDLE. Write throughput becomes 1 per 3 cycles.
  - VERIFY never raises rsp_valid.
- Not defined:
  - No VERIFY state; WRITE -> IDLE.
  - verify_err is constant 0.

Test Plan:
- Reset, then write addr 0 = 0xA5 and addr 3 = 0x3C; read addr 0 and addr 3 -> rsp_data 0xA5 then 0x3C; rsp_valid high exactly 1 cycle each with rsp_ready=1.
- Read addr 1 with rsp_ready=0 for 5 cycles -> rsp_valid stays 1 and rsp_data stays 0x00; ram_cs=0 during stall; releasing rsp_ready returns to IDLE next edge.
- Back-to-back writes with req_valid held high -> req_ready pulses every 2nd cycle (3rd with feature); ram_we is 1 exactly one cycle per write; ram_we and ram_rd are never both 1.
- Assert reset asynchronously mid-READ (between edges) -> ram_cs/ram_rd drop the same cycle; rsp_valid=0; req_ready=1 after reset release.
- With RAM_WRITE_VERIFY_EN, write 0xFF to addr 2 with the RAM model forced to return 0x00 -> verify_err=1 and stays 1 through subsequent good writes until reset.
- Without the feature, the same stimulus -> verify_err=0 and no RD pulse after the write.

Source files
------------

// File: rtl/ram_req_sequencer.sv
// Request sequencer for the 4x8 synchronous RAM: one host read/write per handshake, read data on a response channel.
// Optional read-back check after every write is enabled with `define RAM_WRITE_VERIFY_EN.
module ram_req_sequencer #(
    parameter int ADDR_W = 2,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_cs,
    output logic              ram_we,
    output logic              ram_rd,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout,
    output logic              verify_err
);

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ,
        RESP
`ifdef RAM_WRITE_VERIFY_EN
        , VERIFY
`endif
    } state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              rspValid_q;
    logic              verifyErr_q;

    // RAM strobes depend only on the state register, so reset kills them asynchronously.
    always_comb begin
        req_ready = 1'b0;
        ram_cs    = 1'b0;
        ram_we    = 1'b0;
        ram_rd    = 1'b0;
        case (state_q)
            IDLE:  req_ready = 1'b1;
            WRITE: begin
                ram_cs = 1'b1;
                ram_we = 1'b1;
            end
            READ: begin
                ram_cs = 1'b1;
                ram_rd = 1'b1;
            end
`ifdef RAM_WRITE_VERIFY_EN
            VERIFY: begin
                ram_cs = 1'b1;
                ram_rd = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            rspValid_q  <= 1'b0;
            verifyErr_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        state_q <= req_write ? WRITE : READ;
                    end
                end
                WRITE: begin
`ifdef RAM_WRITE_VERIFY_EN
                    state_q <= VERIFY;
`else
                    state_q <= IDLE;
`endif
                end
                READ: begin
                    rdata_q    <= ram_dout;
                    rspValid_q <= 1'b1;
                    state_q    <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rspValid_q <= 1'b0;
                        state_q    <= IDLE;
                    end
                end
`ifdef RAM_WRITE_VERIFY_EN
                // Error flag is sticky; only reset clears it.
                VERIFY: begin
                    if (ram_dout != wdata_q) begin
                        verifyErr_q <= 1'b1;
                    end
                    state_q <= IDLE;
                end
`endif
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rsp_valid = rspValid_q;
    assign rsp_data  = rdata_q;
    assign ram_addr  = addr_q;
    assign ram_din   = wdata_q;
`ifdef RAM_WRITE_VERIFY_EN
    assign verify_err = verifyErr_q;
`else
    assign verify_err = 1'b0;
`endif

endmodule

// File: tb/tb_ram_req_sequencer.sv
// Self-checking bench for ram_req_sequencer: vector table, random transactions against a memory model, corner sequences.
// Expectations follow RAM_WRITE_VERIFY_EN when the macro is defined.
module tb_ram_req_sequencer;

    logic       clk;
    logic       reset;
    logic       req_valid;
    logic       req_ready;
    logic       req_write;
    logic [1:0] req_addr;
    logic [7:0] req_wdata;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;
    logic [1:0] ram_addr;
    logic       ram_cs;
    logic       ram_we;
    logic       ram_rd;
    logic [7:0] ram_din;
    logic [7:0] ram_dout;
    logic       verify_err;

    int vecCount  = 0;
    int failCount = 0;

    logic [7:0] ramMem [4];
    logic       forceZero;
    logic [7:0] refMem [4];
    logic       errExp;

    typedef struct packed {
        logic       isWrite;
        logic [1:0] addr;
        logic [7:0] wdata;
        logic [7:0] expData;
        logic [3:0] stall;
    } vec_t;

    vec_t vecs [7];

    ram_req_sequencer #(.ADDR_W(2), .DATA_W(8)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .ram_addr(ram_addr), .ram_cs(ram_cs), .ram_we(ram_we), .ram_rd(ram_rd),
        .ram_din(ram_din), .ram_dout(ram_dout), .verify_err(verify_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural 4x8 RAM: synchronous write, combinational read, optional stuck-at-zero read path.
    always @(posedge clk) begin
        if (ram_cs && ram_we) ramMem[ram_addr] <= ram_din;
    end
    assign ram_dout = (ram_cs && ram_rd) ? (forceZero ? 8'h00 : ramMem[ram_addr]) : 8'h00;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vecCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Waits (bounded) for IDLE, performs one handshake, returns at the negedge of the first busy cycle.
    task automatic applyStimulus(input logic isWrite, input logic [1:0] addr, input logic [7:0] data);
        int waited = 0;
        while (!req_ready && waited < 20) begin
            cycle();
            waited++;
        end
        checkOutput("ready_timeout", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_write = isWrite;
        req_addr  = addr;
        req_wdata = data;
        cycle();
        req_valid = 1'b0;
        req_write = 1'($urandom);
        req_addr  = 2'($urandom);
        req_wdata = 8'($urandom);
        checkOutput("busy_ready", {31'd0, req_ready}, 32'd0);
    endtask

    task automatic runWrite(input logic [1:0] addr, input logic [7:0] data);
        applyStimulus(1'b1, addr, data);
        checkOutput("wr_pins", {29'd0, ram_cs, ram_we, ram_rd}, 32'b110);
        checkOutput("wr_addr", {30'd0, ram_addr}, {30'd0, addr});
        checkOutput("wr_din", {24'd0, ram_din}, {24'd0, data});
        cycle();
        refMem[addr] = data;
`ifdef RAM_WRITE_VERIFY_EN
        checkOutput("vfy_pins", {29'd0, ram_cs, ram_we, ram_rd}, 32'b101);
        checkOutput("vfy_rsp", {31'd0, rsp_valid}, 32'd0);
        if (forceZero && data != 8'h00) errExp = 1'b1;
        cycle();
`endif
        checkOutput("wr_done_pins", {28'd0, req_ready, ram_cs, ram_we, ram_rd}, 32'b1000);
        checkOutput("verify_err", {31'd0, verify_err}, {31'd0, errExp});
    endtask

    task automatic runRead(input logic [1:0] addr, input logic [7:0] expData, input int stall);
        rsp_ready = (stall == 0);
        applyStimulus(1'b0, addr, 8'h00);
        checkOutput("rd_pins", {29'd0, ram_cs, ram_we, ram_rd}, 32'b101);
        cycle();
        checkOutput("rsp_valid", {31'd0, rsp_valid}, 32'd1);
        checkOutput("rsp_data", {24'd0, rsp_data}, {24'd0, expData});
        checkOutput("resp_cs", {31'd0, ram_cs}, 32'd0);
        for (int k = 0; k < stall; k++) begin
            cycle();
            checkOutput("stall_valid", {31'd0, rsp_valid}, 32'd1);
            checkOutput("stall_data", {24'd0, rsp_data}, {24'd0, expData});
            checkOutput("stall_pins", {28'd0, req_ready, ram_cs, ram_we, ram_rd}, 32'd0);
        end
        rsp_ready = 1'b1;
        cycle();
        checkOutput("rsp_drop", {30'd0, rsp_valid, req_ready}, 32'b01);
    endtask

    initial begin
        int period;
        for (int i = 0; i < 4; i++) begin
            ramMem[i] = 8'h00;
            refMem[i] = 8'h00;
        end
        forceZero = 1'b0;
        errExp    = 1'b0;
        reset     = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = 2'd0;
        req_wdata = 8'h00;
        rsp_ready = 1'b1;

        vecs[0] = '{1'b1, 2'd0, 8'hA5, 8'h00, 4'd0};
        vecs[1] = '{1'b1, 2'd3, 8'h3C, 8'h00, 4'd0};
        vecs[2] = '{1'b0, 2'd0, 8'h00, 8'hA5, 4'd0};
        vecs[3] = '{1'b0, 2'd3, 8'h00, 8'h3C, 4'd0};
        vecs[4] = '{1'b0, 2'd1, 8'h00, 8'h00, 4'd5};
        vecs[5] = '{1'b1, 2'd2, 8'h77, 8'h00, 4'd0};
        vecs[6] = '{1'b0, 2'd2, 8'h00, 8'h77, 4'd1};

        // Reset state
        repeat (2) @(negedge clk);
        checkOutput("rst_ctrl", {27'd0, req_ready, rsp_valid, ram_cs, ram_we, ram_rd}, 32'b10000);
        checkOutput("rst_data", {rsp_data, ram_din, 6'd0, ram_addr, 7'd0, verify_err}, 32'd0);
        reset = 1'b0;
        cycle();

        // Directed vector table
        for (int i = 0; i < 7; i++) begin
            if (vecs[i].isWrite) runWrite(vecs[i].addr, vecs[i].wdata);
            else runRead(vecs[i].addr, vecs[i].expData, int'(vecs[i].stall));
        end

        // Random transactions against the reference memory
        for (int i = 0; i < 30; i++) begin
            logic [1:0] a;
            a = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) runWrite(a, 8'($urandom));
            else runRead(a, refMem[a], int'($urandom_range(0, 2)));
        end

        // Back-to-back writes with req_valid held high
`ifdef RAM_WRITE_VERIFY_EN
        period = 3;
`else
        period = 2;
`endif
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 2'd1;
        for (int i = 0; i < 12; i++) begin
            req_wdata = 8'h40 + 8'(i);
            checkOutput("b2b_ready", {31'd0, req_ready}, {31'd0, (i % period) == 0});
            checkOutput("b2b_we", {31'd0, ram_we}, {31'd0, (i % period) == 1});
            checkOutput("b2b_we_rd", {31'd0, ram_we & ram_rd}, 32'd0);
            if ((i % period) == 0) refMem[1] = req_wdata;
            cycle();
        end
        req_valid = 1'b0;
        runRead(2'd1, refMem[1], 0);

        // Write-verify with a RAM that reads back zero
        forceZero = 1'b1;
        runWrite(2'd2, 8'hFF);
        forceZero = 1'b0;
        runWrite(2'd0, 8'h5A);
        runRead(2'd2, 8'hFF, 0);
        runRead(2'd0, 8'h5A, 0);

        // Asynchronous reset in the middle of a READ cycle
        applyStimulus(1'b0, 2'd3, 8'h00);
        checkOutput("mid_rd_cs", {31'd0, ram_cs}, 32'd1);
        #2 reset = 1'b1;
        #1;
        checkOutput("async_rst_pins", {28'd0, rsp_valid, ram_cs, ram_we, ram_rd}, 32'd0);
        checkOutput("rst_verify_err", {31'd0, verify_err}, 32'd0);
        errExp = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        cycle();
        checkOutput("post_rst_ready", {30'd0, req_ready, rsp_valid}, 32'b10);

        // Reset while a response is pending discards it
        rsp_ready = 1'b0;
        applyStimulus(1'b0, 2'd3, 8'h00);
        cycle();
        checkOutput("resp_pending", {31'd0, rsp_valid}, 32'd1);
        #2 reset = 1'b1;
        #1;
        checkOutput("resp_discard", {23'd0, rsp_valid, rsp_data}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        rsp_ready = 1'b1;
        cycle();
        checkOutput("resp_rst_idle", {30'd0, req_ready, rsp_valid}, 32'b10);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, failCount);
        $finish;
    end

endmodule
